// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the multi-cycle left-shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int step_w(input int max_step);
        return $clog2(max_step + 1);
    endfunction

    function automatic int unsigned min_u(input int unsigned x, input int unsigned y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Narrow combinational step shifter: out = acc << amt.
module shift_step #(
    parameter int W  = 32,
    parameter int SW = 3
) (
    input  logic [W-1:0]  acc,
    input  logic [SW-1:0] amt,
    output logic [W-1:0]  out
);

    assign out = acc << amt;

endmodule

// File: rtl/shift_sequencer.sv
// Computes c = a << b a few bit positions per cycle using one narrow step shifter.
// state | meaning
// IDLE  | waiting for an operand pair, s_ready high
// BUSY  | shifting acc by up to MAX_STEP per cycle until rem is consumed
// DONE  | result held on c with m_valid high until m_ready
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 5,
    parameter int DATA_WIDTH_C = 32,
    parameter int MAX_STEP     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH_A-1:0] a,
    input  logic [DATA_WIDTH_B-1:0] b,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH_C-1:0] c,
    output logic                    busy
);

    localparam int STEP_W = step_w(MAX_STEP);

    state_t                  state, state_nxt;
    logic [DATA_WIDTH_C-1:0] acc, acc_nxt, acc_shifted, a_ext;
    logic [DATA_WIDTH_B-1:0] rem, rem_nxt, rem_after;
    logic [STEP_W-1:0]       step;

    assign a_ext     = DATA_WIDTH_C'(a);
    assign step      = STEP_W'(min_u(32'(rem), 32'(MAX_STEP)));
    assign rem_after = rem - DATA_WIDTH_B'(step);

    shift_step #(
        .W  (DATA_WIDTH_C),
        .SW (STEP_W)
    ) u_step (
        .acc (acc),
        .amt (step),
        .out (acc_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    acc_nxt = a_ext;
                    rem_nxt = b;
                    if (b == '0) begin
                        state_nxt = DONE;
                    end else if (32'(b) >= 32'(DATA_WIDTH_C)) begin
                        // every bit would be shifted out, so skip the iteration
                        acc_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_nxt = acc_shifted;
                rem_nxt = rem_after;
                if (rem_after == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_ready = (state == IDLE);
    assign m_valid = (state == DONE);
    assign busy    = (state != IDLE);
    assign c       = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed vectors, expected results queued at accept.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] a = '0;
    logic [4:0]  b = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] c;
    logic        busy;

    logic        s2_valid = 1'b0;
    logic        s2_ready;
    logic [15:0] a2 = '0;
    logic [5:0]  b2 = '0;
    logic        m2_valid;
    logic        m2_ready = 1'b1;
    logic [31:0] c2;
    logic        busy2;

    typedef struct {
        logic [31:0] c;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .a       (a),
        .b       (b),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .c       (c),
        .busy    (busy)
    );

    shift_sequencer #(.DATA_WIDTH_B(6)) dut_b6 (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s2_valid),
        .s_ready (s2_ready),
        .a       (a2),
        .b       (b2),
        .m_valid (m2_valid),
        .m_ready (m2_ready),
        .c       (c2),
        .busy    (busy2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drives one operand pair from a negedge, returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] av, input logic [4:0] bv,
                         input logic [31:0] exp_c, input int exp_lat, input bit push);
        exp_t e;
        bit   ok = 0;
        s_valid = 1'b1;
        a = av;
        b = bv;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                if (push) begin
                    e.c = exp_c;
                    e.lat = exp_lat;
                    e.acc_cyc = cyc;
                    sb.push_back(e);
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: a=0x%04h b=%0d never accepted", av, bv);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || !s_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL %s_timeout: pending=%0d s_ready=%0b", name, sb.size(), s_ready);
        end
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Monitor: checks latency on first sight of m_valid, stability while held, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                seen = 0;
            end else begin
                if (m_valid && s_ready) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL excl: m_valid and s_ready both high at cycle %0d", cyc);
                end
                if (m_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: c=0x%08h expected no result", c);
                    end else begin
                        if (!seen) begin
                            seen = 1;
                            check("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
                        end
                        check("c", c, sb[0].c);
                        if (m_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_c", c, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        issue(16'h0001, 5'd0, 32'h0000_0001, 1, 1);
        wait_idle("b0");
        issue(16'h00FF, 5'd9, 32'h0001_FE00, 4, 1);
        issue(16'hFFFF, 5'd31, 32'h8000_0000, 9, 1);
        issue(16'h8001, 5'd17, 32'h0002_0000, 6, 1);
        issue(16'h00A5, 5'd4, 32'h0000_0A50, 2, 1);
        issue(16'h0001, 5'd1, 32'h0000_0002, 2, 1);
        wait_idle("seq");

        // backpressure
        m_ready = 1'b0;
        issue(16'h0003, 5'd4, 32'h0000_0030, 2, 1);
        for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
        s_valid = 1'b1;
        a = 16'hDEAD;
        b = 5'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_c", c, 32'h0000_0030);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_s_ready_after", 32'(s_ready), 32'd1);
        check("bp_m_valid_after", 32'(m_valid), 32'd0);
        wait_idle("bp");

        // reset during the second BUSY cycle
        issue(16'h0001, 5'd20, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_c", c, 32'd0);
        repeat (8) @(negedge clk);
        issue(16'h0002, 5'd1, 32'h0000_0004, 2, 1);
        wait_idle("post_rst");

        // wide shift amount saturates to zero in one edge
        check("b6_s_ready", 32'(s2_ready), 32'd1);
        s2_valid = 1'b1;
        a2 = 16'h1234;
        b2 = 6'd40;
        @(negedge clk);
        s2_valid = 1'b0;
        check("b6_m_valid", 32'(m2_valid), 32'd1);
        check("b6_c", c2, 32'd0);
        @(negedge clk);
        check("b6_idle", 32'(m2_valid), 32'd0);
        s2_valid = 1'b1;
        a2 = 16'h0003;
        b2 = 6'd30;
        @(negedge clk);
        s2_valid = 1'b0;
        for (int i = 0; i < 20 && !m2_valid; i++) @(negedge clk);
        check("b6_c30", c2, 32'hC000_0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
